// File: rtl/hamming_pkg.sv
// Shared types and constants for the SEC-DED Hamming(16,11) memory decoder.
// Holds the FSM state encoding, flag codes, default geometry and bit-position map.
// No logic of its own.
package hamming_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        CHECK,
        WR_HI,
        WR_LO,
        DONE
    } state_t;

    localparam logic [1:0] F_OK  = 2'b00;
    localparam logic [1:0] F_ONE = 2'b01;
    localparam logic [1:0] F_TWO = 2'b10;

    localparam int DEF_NUM_WORDS = 15;
    localparam int DEF_SRC_BASE  = 30;
    localparam int DEF_DST_BASE  = 0;

    // Hamming position of data bit d(j+1); parity bits sit at 0,1,2,4,8.
    function automatic logic [3:0] data_pos(input int j);
        logic [3:0] pos;
        case (j)
            0:       pos = 4'd3;
            1:       pos = 4'd5;
            2:       pos = 4'd6;
            3:       pos = 4'd7;
            default: pos = 4'(j + 5);
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/hamming_check.sv
// Combinational SEC-DED check: 16-bit codeword in, 11 data bits and a 2-bit flag out.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the output follows the input.
module hamming_check
    import hamming_pkg::*;
(
    input  logic [15:0] cw_i,
    output logic [10:0] data_o,
    output logic [1:0]  flags_o
);

    logic [3:0] syn;
    logic       par;
    logic       fix;

    always_comb begin
        syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (cw_i[k]) begin
                syn = syn ^ 4'(k);
            end
        end
        par = ^cw_i;
        // Only a single error (odd parity with nonzero syndrome) touches data;
        // a double error is passed through uncorrected.
        fix = par && (syn != 4'd0);

        for (int j = 0; j < 11; j++) begin
            data_o[j] = cw_i[data_pos(j)] ^ (fix && (syn == data_pos(j)));
        end

        if (par) begin
            flags_o = F_ONE;
        end else if (syn != 4'd0) begin
            flags_o = F_TWO;
        end else begin
            flags_o = F_OK;
        end
    end

endmodule

// File: rtl/hamming_decoder.sv
// Reads NUM_WORDS codewords from memory, SEC-DED decodes them and writes flagged results back.
// Latency: 5 cycles per word; done rises 5*NUM_WORDS edges after the req edge.
// Backpressure: none; memory is assumed single-cycle, req is ignored while a run is active.
module hamming_decoder #(
    parameter int NUM_WORDS = hamming_pkg::DEF_NUM_WORDS,
    parameter int SRC_BASE  = hamming_pkg::DEF_SRC_BASE,
    parameter int DST_BASE  = hamming_pkg::DEF_DST_BASE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);
    import hamming_pkg::*;

    localparam int            IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   cw_q, cw_d;
    logic [10:0]   data_q, data_d;
    logic [1:0]    flags_q, flags_d;
    logic          done_q;

    logic [10:0]   chk_data;
    logic [1:0]    chk_flags;
    logic [7:0]    word_off;
    logic [7:0]    src_lo;
    logic [7:0]    dst_lo;

    hamming_check u_check (
        .cw_i    (cw_q),
        .data_o  (chk_data),
        .flags_o (chk_flags)
    );

    assign word_off = 8'({idx_q, 1'b0});
    assign src_lo   = 8'(SRC_BASE) + word_off;
    assign dst_lo   = 8'(DST_BASE) + word_off;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cw_d        = cw_q;
        data_d      = data_q;
        flags_d     = flags_q;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;

        case (state_q)
            IDLE, DONE: begin
                if (req) begin
                    state_d = RD_HI;
                    idx_d   = '0;
                end
            end
            RD_HI: begin
                mem_addr    = src_lo + 8'd1;
                cw_d[15:8]  = mem_rd_data;
                state_d     = RD_LO;
            end
            RD_LO: begin
                mem_addr    = src_lo;
                cw_d[7:0]   = mem_rd_data;
                state_d     = CHECK;
            end
            CHECK: begin
                data_d      = chk_data;
                flags_d     = chk_flags;
                state_d     = WR_HI;
            end
            WR_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dst_lo + 8'd1;
                mem_wr_data = {flags_q, 3'b000, data_q[10:8]};
                state_d     = WR_LO;
            end
            WR_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dst_lo;
                mem_wr_data = data_q[7:0];
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RD_HI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cw_q    <= '0;
            data_q  <= '0;
            flags_q <= F_OK;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cw_q    <= cw_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            done_q  <= (state_d == DONE);
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: expected writes are queued as memory is loaded
// and popped as the DUT writes; latency, reset and req-ignore behaviour checked per task.
module tb_hamming_decoder;
    import hamming_pkg::*;

    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] dat;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [256];
    wr_t        sb [$];
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    hamming_decoder #(
        .NUM_WORDS (NW),
        .SRC_BASE  (SRC),
        .DST_BASE  (DST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    assign mem_rd_data = mem[mem_addr];

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        c        = '0;
        c[3]     = d[0];
        c[7:5]   = d[3:1];
        c[15:9]  = d[10:4];
        c[1] = c[3] ^ c[5] ^ c[7] ^ c[9]  ^ c[11] ^ c[13] ^ c[15];
        c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        c[4] = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        c[8] = c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        return {c[15:9], c[7:5], c[3]};
    endfunction

    task automatic load_word(input int i, input logic [15:0] cw, input logic [7:0] hi, input logic [7:0] lo);
        mem[8'(SRC + 2 * i)]     = cw[7:0];
        mem[8'(SRC + 2 * i + 1)] = cw[15:8];
        sb.push_back({8'(DST + 2 * i + 1), hi});
        sb.push_back({8'(DST + 2 * i), lo});
    endtask

    task automatic start_req();
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b need 0", done); end
        n_vec++;
        if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b need 0", mem_wr_en); end
        n_vec++;
        if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr got %02h need 00", mem_addr); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({done, mem_wr_en, mem_addr, mem_wr_data} !== 18'h0) begin
            n_bad++;
            $display("FAIL idle_outputs got done=%b wr=%b addr=%02h wd=%02h need all 0",
                     done, mem_wr_en, mem_addr, mem_wr_data);
        end
    endtask

    task automatic test_directed();
        logic [10:0] d;
        wr_t         e;
        int          seen;
        load_word(0, 16'h0000, 8'h00, 8'h00);
        load_word(1, 16'hFFFF, 8'h07, 8'hFF);
        load_word(2, 16'hFFFE, 8'h47, 8'hFF);
        load_word(3, 16'h0020, 8'h40, 8'h00);
        load_word(4, 16'h0003, 8'h80, 8'h00);
        for (int i = 5; i < NW; i++) begin
            d = 11'(i * 173);
            load_word(i, encode(d), {5'b00000, d[10:8]}, d[7:0]);
        end
        start_req();
        seen = 0;
        for (int cyc = 1; cyc <= 200 && seen == 0; cyc++) begin
            @(posedge clk);
            #1;
            if (mem_wr_en) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL directed_extra_write addr=%02h data=%02h", mem_addr, mem_wr_data);
                end else begin
                    e = sb.pop_front();
                    if ({mem_addr, mem_wr_data} !== e) begin
                        n_bad++;
                        $display("FAIL directed_write got addr=%02h data=%02h need addr=%02h data=%02h",
                                 mem_addr, mem_wr_data, e.addr, e.dat);
                    end
                end
            end
            if (done) seen = cyc;
        end
        n_vec++;
        if (seen != 75) begin n_bad++; $display("FAIL directed_latency got %0d need 75", seen); end
        n_vec++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL directed_missing got %0d pending need 0", sb.size()); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({done, mem_wr_en, mem_addr, mem_wr_data} !== {1'b1, 17'h0}) begin
            n_bad++;
            $display("FAIL done_hold got done=%b wr=%b addr=%02h wd=%02h need done=1 rest 0",
                     done, mem_wr_en, mem_addr, mem_wr_data);
        end
    endtask

    task automatic test_random_with_req_noise();
        logic [10:0] d;
        logic [15:0] cw;
        logic [1:0]  f;
        int          nf, b1, b2, seen;
        wr_t         e;
        for (int i = 0; i < NW; i++) begin
            d  = 11'($urandom_range(0, 2047));
            cw = encode(d);
            nf = $urandom_range(0, 2);
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            if (nf >= 1) cw[b1] = ~cw[b1];
            if (nf == 2) cw[b2] = ~cw[b2];
            if (nf == 0) f = F_OK;
            else if (nf == 1) f = F_ONE;
            else begin
                f = F_TWO;
                d = extract(cw);
            end
            load_word(i, cw, {f, 3'b000, d[10:8]}, d[7:0]);
        end
        start_req();
        seen = 0;
        for (int cyc = 1; cyc <= 200 && seen == 0; cyc++) begin
            @(posedge clk);
            #1;
            if (mem_wr_en) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL random_extra_write addr=%02h data=%02h", mem_addr, mem_wr_data);
                end else begin
                    e = sb.pop_front();
                    if ({mem_addr, mem_wr_data} !== e) begin
                        n_bad++;
                        $display("FAIL random_write got addr=%02h data=%02h need addr=%02h data=%02h",
                                 mem_addr, mem_wr_data, e.addr, e.dat);
                    end
                end
            end
            if (done) seen = cyc;
            req = (cyc == 20 || cyc == 41 || cyc == 63) ? 1'b1 : 1'b0;
        end
        req = 1'b0;
        n_vec++;
        if (seen != 75) begin n_bad++; $display("FAIL random_latency got %0d need 75", seen); end
        n_vec++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL random_missing got %0d pending need 0", sb.size()); end
    endtask

    task automatic test_reset_midrun();
        logic [10:0] d;
        wr_t         e;
        int          seen;
        for (int i = 0; i < NW; i++) begin
            d = 11'($urandom_range(0, 2047));
            load_word(i, encode(d), {5'b00000, d[10:8]}, d[7:0]);
        end
        start_req();
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(posedge clk);
            #1;
            if (mem_wr_en) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL partial_extra_write addr=%02h data=%02h", mem_addr, mem_wr_data);
                end else begin
                    e = sb.pop_front();
                    if ({mem_addr, mem_wr_data} !== e) begin
                        n_bad++;
                        $display("FAIL partial_write got addr=%02h data=%02h need addr=%02h data=%02h",
                                 mem_addr, mem_wr_data, e.addr, e.dat);
                    end
                end
            end
        end
        n_vec++;
        if (mem_wr_en !== 1'b1) begin n_bad++; $display("FAIL word3_writing got %b need 1", mem_wr_en); end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({done, mem_wr_en, mem_addr} !== 10'h0) begin
            n_bad++;
            $display("FAIL async_reset got done=%b wr=%b addr=%02h need all 0", done, mem_wr_en, mem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_held_wr got %b need 0", mem_wr_en); end
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < NW; i++) begin
            d = 11'($urandom_range(0, 2047));
            load_word(i, encode(d), {5'b00000, d[10:8]}, d[7:0]);
        end
        start_req();
        seen = 0;
        for (int cyc = 1; cyc <= 200 && seen == 0; cyc++) begin
            @(posedge clk);
            #1;
            if (mem_wr_en) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL restart_extra_write addr=%02h data=%02h", mem_addr, mem_wr_data);
                end else begin
                    e = sb.pop_front();
                    if ({mem_addr, mem_wr_data} !== e) begin
                        n_bad++;
                        $display("FAIL restart_write got addr=%02h data=%02h need addr=%02h data=%02h",
                                 mem_addr, mem_wr_data, e.addr, e.dat);
                    end
                end
            end
            if (done) seen = cyc;
            req = (cyc == 7) ? 1'b1 : 1'b0;
        end
        req = 1'b0;
        n_vec++;
        if (seen != 75) begin n_bad++; $display("FAIL restart_latency got %0d need 75", seen); end
        n_vec++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL restart_missing got %0d pending need 0", sb.size()); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        test_reset();
        test_directed();
        test_random_with_req_noise();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
